maze_grid_tracker: RTL and testbench

//  Parametrised successor to the 5x5 maze map. Holds a ROWS x COLS grid of cell codes: empty, agent, wall, goal, visited.

---
 rtl/maze_pkg.sv | 26 ++
 rtl/maze_grid_tracker_if.sv | 41 ++++
 rtl/maze_row_reader.sv | 39 +++
 rtl/maze_grid_tracker.sv | 176 +++++++++++++++++
 tb/tb_maze_grid_tracker.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared cell codes, FSM states and helpers for the maze grid tracker.
package maze_pkg;

   localparam int CELL_W = 3;

   typedef logic [CELL_W-1:0] cell_t;

   localparam cell_t CELL_EMPTY   = 3'd0;
   localparam cell_t CELL_AGENT   = 3'd1;
   localparam cell_t CELL_WALL    = 3'd2;
   localparam cell_t CELL_GOAL    = 3'd3;
   localparam cell_t CELL_VISITED = 3'd4;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   // Only static terrain may be loaded; anything else becomes empty floor.
   function automatic cell_t load_code(cell_t c);
      return (c == CELL_WALL || c == CELL_GOAL) ? c : CELL_EMPTY;
   endfunction

endpackage

// File: rtl/maze_grid_tracker_if.sv
// Control, move and read-port bundle between the agent logic and the tracker.
interface maze_grid_tracker_if #(
   parameter int ROWS = 5,
   parameter int COLS = 5
);
   import maze_pkg::*;

   localparam int N      = ROWS * COLS;
   localparam int IDX_W  = $clog2(N);
   localparam int RSEL_W = $clog2(ROWS);

   logic                   clear_req;
   logic                   load_en;
   logic [IDX_W-1:0]       load_addr;
   cell_t                  load_data;
   logic                   start;
   logic                   pos_valid;
   logic [IDX_W-1:0]       pos_idx;
   logic [RSEL_W-1:0]      row_sel;
   logic [COLS*CELL_W-1:0] row_data;
   logic [IDX_W-1:0]       agent_idx;
   logic                   illegal_move;
   logic                   at_goal;
   logic [IDX_W:0]         visited_cnt;
   logic                   busy;

   modport master (
      output clear_req, load_en, load_addr, load_data,
      output start, pos_valid, pos_idx, row_sel,
      input  row_data, agent_idx, illegal_move,
      input  at_goal, visited_cnt, busy
   );

   modport slave (
      input  clear_req, load_en, load_addr, load_data,
      input  start, pos_valid, pos_idx, row_sel,
      output row_data, agent_idx, illegal_move,
      output at_goal, visited_cnt, busy
   );

endinterface

// File: rtl/maze_row_reader.sv
// Selects one grid row from the flattened cell vector and registers it.
module maze_row_reader
   import maze_pkg::*;
#(
   parameter int ROWS = 5,
   parameter int COLS = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ROWS*COLS*CELL_W-1:0] grid_i,
   input  logic [$clog2(ROWS)-1:0]     row_sel_i,
   output logic [COLS*CELL_W-1:0]      row_data_o
);

   localparam int RSEL_W = $clog2(ROWS);
   localparam int ROW_W  = COLS * CELL_W;

   logic [ROW_W-1:0] row_d;
   logic [ROW_W-1:0] row_q;

   // Unmatched selects (row_sel >= ROWS) fall through to zero.
   always_comb begin
      row_d = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_sel_i == RSEL_W'(r))
            row_d = grid_i[r*ROW_W +: ROW_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         row_q <= '0;
      else
         row_q <= row_d;
   end

   assign row_data_o = row_q;

endmodule

// File: rtl/maze_grid_tracker.sv
// ROWS x COLS maze map: clear sweep, terrain load, agent moves and goal tracking.
module maze_grid_tracker
   import maze_pkg::*;
#(
   parameter int ROWS      = 5,
   parameter int COLS      = 5,
   parameter int START_IDX = 0
) (
   input  logic                clk,
   input  logic                rst,
   maze_grid_tracker_if.slave  bus
);

   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);

   localparam logic [IDX_W-1:0] START   = IDX_W'(START_IDX);
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(N - 1);
   localparam logic [IDX_W:0]   CNT_MAX = (IDX_W + 1)'(N);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] agent_q, agent_d;
   logic             ill_q, ill_d;
   logic             goal_q, goal_d;
   logic [IDX_W:0]   cnt_q, cnt_d;

   cell_t grid_q [N];
   logic [N*CELL_W-1:0] grid_flat;

   logic             we0, we1;
   logic [IDX_W-1:0] wa0, wa1;
   cell_t            wd0, wd1;

   logic  pos_ok;
   logic  load_ok;
   cell_t tgt;

   always_comb begin
      pos_ok  = int'(bus.pos_idx) < N;
      load_ok = int'(bus.load_addr) < N;
      tgt     = CELL_EMPTY;
      if (pos_ok)
         tgt = grid_q[bus.pos_idx];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      agent_d = agent_q;
      ill_d   = 1'b0;
      goal_d  = goal_q;
      cnt_d   = cnt_q;
      we0     = 1'b0;
      wa0     = '0;
      wd0     = CELL_EMPTY;
      we1     = 1'b0;
      wa1     = '0;
      wd1     = CELL_EMPTY;

      if (bus.clear_req) begin
         state_d = S_CLEAR;
         ptr_d   = '0;
         agent_d = '0;
         goal_d  = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_CLEAR: begin
               we0   = 1'b1;
               wa0   = ptr_q;
               wd0   = CELL_EMPTY;
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == LAST) begin
                  ptr_d   = '0;
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               if (bus.load_en && load_ok) begin
                  we0 = 1'b1;
                  wa0 = bus.load_addr;
                  wd0 = load_code(bus.load_data);
               end
               // Port 1 lands after port 0, so the agent wins a shared address.
               if (bus.start) begin
                  we1     = 1'b1;
                  wa1     = START;
                  wd1     = CELL_AGENT;
                  agent_d = START;
                  cnt_d   = (IDX_W + 1)'(1);
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (bus.pos_valid) begin
                  if (!pos_ok || tgt == CELL_WALL) begin
                     ill_d = 1'b1;
                  end else if (bus.pos_idx != agent_q) begin
                     we0     = 1'b1;
                     wa0     = agent_q;
                     wd0     = CELL_VISITED;
                     we1     = 1'b1;
                     wa1     = bus.pos_idx;
                     wd1     = CELL_AGENT;
                     agent_d = bus.pos_idx;
                     if ((tgt == CELL_EMPTY || tgt == CELL_GOAL)
                         && cnt_q < CNT_MAX)
                        cnt_d = cnt_q + 1'b1;
                     if (tgt == CELL_GOAL) begin
                        goal_d  = 1'b1;
                        state_d = S_DONE;
                     end
                  end
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_CLEAR;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_CLEAR;
         ptr_q   <= '0;
         agent_q <= '0;
         ill_q   <= 1'b0;
         goal_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         agent_q <= agent_d;
         ill_q   <= ill_d;
         goal_q  <= goal_d;
         cnt_q   <= cnt_d;
      end
   end

   // Cell storage is deliberately unreset; the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (we0)
         grid_q[wa0] <= wd0;
      if (we1)
         grid_q[wa1] <= wd1;
   end

   always_comb begin
      grid_flat = '0;
      for (int i = 0; i < N; i++)
         grid_flat[i*CELL_W +: CELL_W] = grid_q[i];
   end

   maze_row_reader #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_row_reader (
      .clk        (clk),
      .rst        (rst),
      .grid_i     (grid_flat),
      .row_sel_i  (bus.row_sel),
      .row_data_o (bus.row_data)
   );

   assign bus.agent_idx    = agent_q;
   assign bus.illegal_move = ill_q;
   assign bus.at_goal      = goal_q;
   assign bus.visited_cnt  = cnt_q;
   assign bus.busy         = (state_q == S_CLEAR);

endmodule

// File: tb/tb_maze_grid_tracker.sv
// Self-checking bench for maze_grid_tracker on a 5x5 grid.
module tb_maze_grid_tracker;

   localparam int ROWS = 5;
   localparam int COLS = 5;
   localparam int N    = ROWS * COLS;

   typedef struct {
      int pos;
      int agent;
      int cnt;
      bit ill;
      bit goal;
   } mv_t;

   logic clk;
   logic rst;

   int n_chk;
   int n_fail;

   int mgrid [N];
   logic [14:0] exp_q [$];

   maze_grid_tracker_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   maze_grid_tracker #(
      .ROWS      (ROWS),
      .COLS      (COLS),
      .START_IDX (0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] row_exp(int r);
      logic [14:0] v;
      v = '0;
      if (r < ROWS) begin
         for (int c = 0; c < COLS; c++)
            v[c*3 +: 3] = 3'(mgrid[r*COLS + c]);
      end
      return v;
   endfunction

   task automatic read_row(int r);
      bus.row_sel = 3'(r);
      exp_q.push_back(row_exp(r));
      tick();
      check($sformatf("row_data[%0d]", r), 32'(bus.row_data),
            32'(exp_q.pop_front()));
   endtask

   task automatic wait_idle(string name);
      int n;
      n = 0;
      while (bus.busy && n < 100) begin
         tick();
         n++;
      end
      check(name, n, 25);
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++)
         mgrid[i] = 0;
   endtask

   initial begin
      mv_t mv [8];
      int  prev;

      mv[0] = '{pos: 7,  agent: 0,  cnt: 1, ill: 1, goal: 0};
      mv[1] = '{pos: 30, agent: 0,  cnt: 1, ill: 1, goal: 0};
      mv[2] = '{pos: 1,  agent: 1,  cnt: 2, ill: 0, goal: 0};
      mv[3] = '{pos: 0,  agent: 0,  cnt: 2, ill: 0, goal: 0};
      mv[4] = '{pos: 1,  agent: 1,  cnt: 2, ill: 0, goal: 0};
      mv[5] = '{pos: 1,  agent: 1,  cnt: 2, ill: 0, goal: 0};
      mv[6] = '{pos: 24, agent: 24, cnt: 3, ill: 0, goal: 1};
      mv[7] = '{pos: 5,  agent: 24, cnt: 3, ill: 0, goal: 1};

      n_chk  = 0;
      n_fail = 0;
      model_clear();

      rst           = 1'b1;
      bus.clear_req = 1'b0;
      bus.load_en   = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus.start     = 1'b0;
      bus.pos_valid = 1'b0;
      bus.pos_idx   = '0;
      bus.row_sel   = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 1);
      check("rst_row", 32'(bus.row_data), 0);
      check("rst_agent", 32'(bus.agent_idx), 0);
      check("rst_cnt", 32'(bus.visited_cnt), 0);
      check("rst_goal", 32'(bus.at_goal), 0);
      check("rst_ill", 32'(bus.illegal_move), 0);
      rst = 1'b0;

      wait_idle("sweep_len");
      for (int r = 0; r < ROWS; r++)
         read_row(r);

      bus.load_en   = 1'b1;
      bus.load_addr = 5'd7;
      bus.load_data = 3'd2;
      tick();
      bus.load_addr = 5'd24;
      bus.load_data = 3'd3;
      tick();
      bus.load_en = 1'b0;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      mgrid[7]  = 2;
      mgrid[24] = 3;
      mgrid[0]  = 1;
      check("start_agent", 32'(bus.agent_idx), 0);
      check("start_cnt", 32'(bus.visited_cnt), 1);
      check("start_busy", 32'(bus.busy), 0);
      read_row(0);
      read_row(1);
      read_row(4);

      prev = 0;
      for (int i = 0; i < 8; i++) begin
         bus.pos_valid = 1'b1;
         bus.pos_idx   = 5'(mv[i].pos);
         tick();
         bus.pos_valid = 1'b0;
         check($sformatf("mv%0d_agent", i), 32'(bus.agent_idx), mv[i].agent);
         check($sformatf("mv%0d_cnt", i), 32'(bus.visited_cnt), mv[i].cnt);
         check($sformatf("mv%0d_ill", i), 32'(bus.illegal_move),
               32'(mv[i].ill));
         check($sformatf("mv%0d_goal", i), 32'(bus.at_goal),
               32'(mv[i].goal));
         if (mv[i].agent != prev) begin
            mgrid[prev]        = 4;
            mgrid[mv[i].agent] = 1;
            prev               = mv[i].agent;
         end
         tick();
         check($sformatf("mv%0d_pulse", i), 32'(bus.illegal_move), 0);
      end
      read_row(0);
      read_row(1);
      read_row(4);

      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      check("clr_goal", 32'(bus.at_goal), 0);
      check("clr_cnt", 32'(bus.visited_cnt), 0);
      check("clr_agent", 32'(bus.agent_idx), 0);
      check("clr_busy", 32'(bus.busy), 1);
      repeat (9) tick();
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      wait_idle("resweep_len");
      model_clear();
      read_row(1);

      bus.load_en   = 1'b1;
      bus.load_addr = 5'd2;
      bus.load_data = 3'd4;
      tick();
      bus.load_addr = 5'd0;
      bus.load_data = 3'd2;
      bus.start     = 1'b1;
      tick();
      bus.load_en = 1'b0;
      bus.start   = 1'b0;
      mgrid[0]    = 1;
      read_row(0);
      read_row(5);

      bus.pos_valid = 1'b1;
      bus.pos_idx   = 5'd2;
      tick();
      bus.pos_valid = 1'b0;
      check("run2_cnt", 32'(bus.visited_cnt), 2);
      check("run2_agent", 32'(bus.agent_idx), 2);
      mgrid[0] = 4;
      mgrid[2] = 1;
      read_row(0);

      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      check("runclr_cnt", 32'(bus.visited_cnt), 0);
      check("runclr_agent", 32'(bus.agent_idx), 0);
      check("runclr_busy", 32'(bus.busy), 1);
      wait_idle("runclr_len");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
